// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the noise generator and the stream checker.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents: word width, feedback taps, the one-step LFSR function, the
// checker state encodings and a 32-bit popcount helper.
package lfsr_pkg;

   localparam int LFSR_WIDTH = 32;

   // Feedback taps: next(s) = {s[30:0], s[31]^s[21]^s[1]^s[0]}
   localparam int LFSR_TAP_A = 31;
   localparam int LFSR_TAP_B = 21;
   localparam int LFSR_TAP_C = 1;
   localparam int LFSR_TAP_D = 0;

   typedef logic [LFSR_WIDTH-1:0] lfsr_word_t;

   // Encodings are visible on the checker's O_state port.
   typedef enum logic [1:0] {
      CHK_IDLE    = 2'd0,
      CHK_ACQUIRE = 2'd1,
      CHK_VERIFY  = 2'd2,
      CHK_LOCKED  = 2'd3
   } chk_state_t;

   function automatic lfsr_word_t lfsr_next(input lfsr_word_t s);
      return {s[LFSR_WIDTH-2:0],
              s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
   endfunction

   function automatic logic [5:0] popcount32(input lfsr_word_t v);
      logic [5:0] c;
      c = '0;
      for (int i = 0; i < LFSR_WIDTH; i++) begin
         c = c + {5'd0, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/lfsr_deser32.sv
// Serial-to-word deserialiser: MSB-first bits shifted in at the LSB.
// Latency: word_dat/word_vld update on the edge that samples the 32nd bit.
// Backpressure: none; input is valid-qualified only, gaps of any length allowed.
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   flush     - clear the bit counter and drop any partial word
//   ser_bit   - serial data bit, ser_vld qualifies it
//   word_dat  - last completed 32-bit word (held until the next one)
//   word_vld  - one-cycle strobe following completion of word_dat
module lfsr_deser32
   import lfsr_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       ser_bit,
   input  logic       ser_vld,
   output lfsr_word_t word_dat,
   output logic       word_vld
);

   logic [4:0] bit_cnt;
   lfsr_word_t shreg;
   lfsr_word_t shreg_nxt;

   assign shreg_nxt = {shreg[LFSR_WIDTH-2:0], ser_bit};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt  <= '0;
         shreg    <= '0;
         word_dat <= '0;
         word_vld <= 1'b0;
      end else begin
         word_vld <= 1'b0;
         if (flush) begin
            // Shift register contents are irrelevant once the counter
            // restarts: a full 32 fresh bits are needed before the next strobe.
            bit_cnt <= '0;
         end else if (ser_vld) begin
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd31) begin
               word_dat <= shreg_nxt;
               word_vld <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/lfsr_stream_checker.sv
// Receive-side LFSR stream checker: deserialise, self-seed, verify, report lock and errors.
// Latency: counters/state update 1 clock after the edge that samples a word's 32nd bit.
// Backpressure: none; the serial input is valid-qualified and never stalled.
//
// Build option: define LFSR_CHK_BITERR_EN to build the per-bit error counter
// (popcount of each compared word against its prediction); otherwise
// O_bit_err_count is tied to 0.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   I_enable          - low forces IDLE (highest priority)
//   I_clear           - pulse: zero all statistics counters, state untouched
//   I_resync          - pulse: back to ACQUIRE, partial word discarded
//   I_bit/I_bit_valid - MSB-first serial stream
//   O_state/O_locked  - checker state (0 IDLE,1 ACQUIRE,2 VERIFY,3 LOCKED)
//   O_word_count      - words compared in VERIFY/LOCKED (saturating)
//   O_word_err_count  - mismatched words (saturating)
//   O_bit_err_count   - mismatched bits (saturating, option only)
//   O_last_word       - last assembled word
//   O_expected        - current prediction for the next word
module lfsr_stream_checker
   import lfsr_pkg::*;
#(
   parameter int CONFIRM_WORDS = 2,
   parameter int LOSS_THRESH   = 4,
   parameter int WERR_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  I_enable,
   input  logic                  I_clear,
   input  logic                  I_resync,
   input  logic                  I_bit,
   input  logic                  I_bit_valid,
   output logic [1:0]            O_state,
   output logic                  O_locked,
   output logic [31:0]           O_word_count,
   output logic [WERR_WIDTH-1:0] O_word_err_count,
   output logic [31:0]           O_bit_err_count,
   output logic [31:0]           O_last_word,
   output logic [31:0]           O_expected
);

   localparam logic [3:0]            CONFIRM_LAST = 4'(CONFIRM_WORDS - 1);
   localparam logic [3:0]            LOSS_LAST    = 4'(LOSS_THRESH - 1);
   localparam logic [WERR_WIDTH-1:0] WERR_ONE     = WERR_WIDTH'(1);

   chk_state_t state_q, state_d;
   lfsr_word_t expected_q, expected_d;
   lfsr_word_t seed_q, seed_d;
   logic       rep_ok_q, rep_ok_d;
   logic [3:0] match_q, match_d;
   logic [3:0] miss_q, miss_d;

   logic       flush;
   logic       word_vld;
   logic       word_match;
   logic       rep_hit;
   logic       cmp_evt;
   logic       cmp_err;

   logic [31:0]           word_cnt_q;
   logic [WERR_WIDTH-1:0] word_err_q;

   // ------------------------------------------------------------------
   // Deserialiser: idle whenever the checker is idle or being resynced.
   // ------------------------------------------------------------------
   assign flush = !I_enable || I_resync || (state_q == CHK_IDLE);

   lfsr_deser32 u_deser (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .ser_bit  (I_bit),
      .ser_vld  (I_bit_valid),
      .word_dat (O_last_word),
      .word_vld (word_vld)
   );

   assign word_match = (O_last_word == expected_q);
   // The generator may emit its seed word twice around a restart; the first
   // word after seeding is allowed to repeat the seed once.
   assign rep_hit    = rep_ok_q && (O_last_word == seed_q);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= CHK_IDLE;
         expected_q <= '0;
         seed_q     <= '0;
         rep_ok_q   <= 1'b0;
         match_q    <= '0;
         miss_q     <= '0;
      end else begin
         state_q    <= state_d;
         expected_q <= expected_d;
         seed_q     <= seed_d;
         rep_ok_q   <= rep_ok_d;
         match_q    <= match_d;
         miss_q     <= miss_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and compare decode
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      expected_d = expected_q;
      seed_d     = seed_q;
      rep_ok_d   = rep_ok_q;
      match_d    = match_q;
      miss_d     = miss_q;
      cmp_evt    = 1'b0;
      cmp_err    = 1'b0;

      if (!I_enable) begin
         state_d  = CHK_IDLE;
         rep_ok_d = 1'b0;
         match_d  = '0;
         miss_d   = '0;
      end else if (I_resync) begin
         state_d  = CHK_ACQUIRE;
         rep_ok_d = 1'b0;
         match_d  = '0;
         miss_d   = '0;
      end else begin
         case (state_q)
            CHK_IDLE: begin
               state_d = CHK_ACQUIRE;
            end

            CHK_ACQUIRE: begin
               // All-zero is the LFSR lockup state and cannot seed a predictor.
               if (word_vld && (O_last_word != '0)) begin
                  seed_d     = O_last_word;
                  expected_d = lfsr_next(O_last_word);
                  rep_ok_d   = 1'b1;
                  match_d    = '0;
                  miss_d     = '0;
                  state_d    = CHK_VERIFY;
               end
            end

            CHK_VERIFY: begin
               if (word_vld) begin
                  cmp_evt  = 1'b1;
                  rep_ok_d = 1'b0;
                  if (word_match) begin
                     expected_d = lfsr_next(O_last_word);
                     if (match_q == CONFIRM_LAST) begin
                        match_d = '0;
                        miss_d  = '0;
                        state_d = CHK_LOCKED;
                     end else begin
                        match_d = match_q + 4'd1;
                     end
                  end else if (!rep_hit) begin
                     cmp_err = 1'b1;
                     match_d = '0;
                     state_d = CHK_ACQUIRE;
                  end
                  // A tolerated repeat neither counts as a match nor
                  // advances the prediction.
               end
            end

            CHK_LOCKED: begin
               if (word_vld) begin
                  cmp_evt = 1'b1;
                  // Flywheel: the prediction advances on its own so an
                  // isolated corrupted word does not derail tracking.
                  expected_d = lfsr_next(expected_q);
                  if (word_match) begin
                     miss_d = '0;
                  end else begin
                     cmp_err = 1'b1;
                     if (miss_q == LOSS_LAST) begin
                        miss_d  = '0;
                        state_d = CHK_ACQUIRE;
                     end else begin
                        miss_d = miss_q + 4'd1;
                     end
                  end
               end
            end

            default: begin
               state_d = CHK_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Statistics counters: saturating, clear wins over increment.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_cnt_q <= '0;
         word_err_q <= '0;
      end else if (I_clear) begin
         word_cnt_q <= '0;
         word_err_q <= '0;
      end else begin
         if (cmp_evt && (word_cnt_q != '1)) begin
            word_cnt_q <= word_cnt_q + 32'd1;
         end
         if (cmp_err && (word_err_q != '1)) begin
            word_err_q <= word_err_q + WERR_ONE;
         end
      end
   end

`ifdef LFSR_CHK_BITERR_EN
   logic [5:0]  bit_diff;
   logic [32:0] bit_sum;
   logic [31:0] bit_err_q;

   // Matching words contribute zero anyway, so only mismatches need the popcount.
   assign bit_diff = cmp_err ? popcount32(O_last_word ^ expected_q) : 6'd0;
   assign bit_sum  = {1'b0, bit_err_q} + {27'd0, bit_diff};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_err_q <= '0;
      end else if (I_clear) begin
         bit_err_q <= '0;
      end else if (bit_sum[32]) begin
         bit_err_q <= '1;
      end else begin
         bit_err_q <= bit_sum[31:0];
      end
   end

   assign O_bit_err_count = bit_err_q;
`else
   assign O_bit_err_count = '0;
`endif

   assign O_state          = state_q;
   assign O_locked         = (state_q == CHK_LOCKED);
   assign O_word_count     = word_cnt_q;
   assign O_word_err_count = word_err_q;
   assign O_expected       = expected_q;

endmodule

// File: doc/lfsr_stream_checker.md
Name: lfsr_stream_checker

Overview:
Receive-side companion to the noise LFSR generator. Deserialises the MSB-first serial LFSR bit stream (bit plus valid) into 32-bit words. Self-synchronises by seeding a local predictor from a received word, then checks every later word against the predicted LFSR step. Reports lock status and error counters to the register block for noise-path self-test.

Parameters:
CONFIRM_WORDS, 2, consecutive matching words required in VERIFY before LOCKED (1..15)
LOSS_THRESH, 4, consecutive mismatched words in LOCKED before falling back to ACQUIRE (1..15)
WERR_WIDTH, 16, width of the word-error counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
I_enable  in  1  checker enable; low forces IDLE
I_clear  in  1  synchronous pulse: clear all counters (state unaffected)
I_resync  in  1  synchronous pulse: drop to ACQUIRE, discard partial word
I_bit  in  1  serial data, MSB of word first
I_bit_valid  in  1  I_bit qualifier
O_state  out  2  0 IDLE, 1 ACQUIRE, 2 VERIFY, 3 LOCKED
O_locked  out  1  O_state == LOCKED
O_word_count  out  32  words checked in VERIFY/LOCKED, saturating
O_word_err_count  out  WERR_WIDTH  mismatched words, saturating
O_bit_err_count  out  32  mismatched bits, saturating (feature only; else 0)
O_last_word  out  32  last assembled word
O_expected  out  32  current prediction

Behaviour:
- Reset: all outputs 0, state IDLE, bit counter 0, shift register 0.
- LFSR step (shared with the generator): next(s) = {s[30:0], s[31]^s[21]^s[1]^s[0]}.
- Deserialiser: on each I_bit_valid cycle, shift in I_bit at LSB and increment the 5-bit counter. On the cycle the 32nd bit is sampled (counter 31->0 wrap), the word is registered into O_last_word and a one-cycle word strobe is raised. Valid gaps of any length are tolerated. Deserialiser runs only outside IDLE.
- Compare and counter updates happen on the edge after the strobe. Latency from 32nd-bit edge to counter/state update is 1 clock.
- IDLE: I_enable=1 -> ACQUIRE, bit counter cleared.
- ACQUIRE: on strobe, a nonzero word W loads O_expected<=next(W) -> VERIFY. An all-zero word (LFSR lockup) is ignored, so the block stays in ACQUIRE. No counters change in ACQUIRE.
- VERIFY: on strobe, if W==O_expected: match count++, O_expected<=next(W); match count==CONFIRM_WORDS -> LOCKED. Repeat tolerance: the first word after seeding that equals the seed is accepted once without advancing O_expected. On mismatch -> ACQUIRE, word_err++.
- LOCKED: match -> O_expected<=next(O_expected), miss count cleared. Mismatch -> word_err++, miss count++, O_expected still advances (flywheel); miss count==LOSS_THRESH -> ACQUIRE.
- O_word_count increments on every compare in VERIFY/LOCKED.
- All counters saturate at all-ones with no wrap.
- Priority: I_enable=0 > I_resync > strobe processing. I_resync also clears the bit counter and match/miss counts. I_clear coincident with a counter increment results in 0.
- Deasserting I_enable mid-word -> IDLE next cycle, partial word discarded, counters retained.

Optional Feature:
LFSR_CHK_BITERR_EN: when defined, on each compare add popcount(W ^ O_expected) (0..32) to O_bit_err_count, saturating, with the same latency as the word counters. A registered popcount stage is allowed, adding 1 cycle to the bit counter only. When undefined, O_bit_err_count is tied to 0 and no popcount logic is built.

Decomposition:
- Package lfsr_pkg:
  - LFSR_WIDTH=32
  - tap constants (31,21,1,0)
  - lfsr_next function
  - O_state encodings CHK_IDLE/CHK_ACQUIRE/CHK_VERIFY/CHK_LOCKED
  - shared with the generator
- Sub-module lfsr_deser32: serial-to-word shifter, bit counter, word strobe.

Test Plan:
- Seed stream 0x00000001,0x00000003,0x00000006,0x0000000D, CONFIRM_WORDS=2 -> VERIFY after word 1, LOCKED after word 3, word_count=2, errors 0.
- Stream 0x00000001,0x00000001,0x00000003,0x00000006 -> repeat accepted once, LOCKED, word_err 0.
- Locked stream, then flip bits 0 and 31 of one word -> word_err=1, bit_err=2 (feature on), remains LOCKED; 4 garbage words -> ACQUIRE.
- All-zero words x3 then 0x00000001 -> stays ACQUIRE through the zeros, then VERIFY.
- Bit valid every 3rd cycle, and I_enable dropped after 17 bits -> IDLE next cycle, partial discarded; re-enable resyncs cleanly.
- Assert rst mid-word while LOCKED -> all outputs 0 immediately (async); word_err held at 0xFFFF saturation check with I_clear -> 0.
